// File: rtl/ser_key_arbiter.sv
// ser_key_arbiter: shares the serial-key device between two requesters, with a sequence lock.
// Ports:
//   clk, rst           system clock, async active-high reset
//   reqN_*             requester N: valid/rd/nib/lock in, ready out
//   rspN_valid/data    completion pulse and sampled SDRD (0 for steps)
//   lock_drop          pulse when an idle lock is force-released
//   key_*              device pins: select (low), address, R/W, clock, read data
module ser_key_arbiter #(
  parameter int SETUP_CYC = 2,
  parameter int LOCK_TMO  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rd,
  input  logic [3:0] req0_nib,
  input  logic       req0_lock,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic       rsp0_data,
  input  logic       req1_valid,
  input  logic       req1_rd,
  input  logic [3:0] req1_nib,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic       rsp1_data,
  output logic       lock_drop,
  output logic       key_sser,
  output logic [5:0] key_ba,
  output logic       key_br_w,
  output logic       key_clk,
  input  logic       key_sdrd
);
  typedef enum logic [1:0] {IDLE, SETUP, CLK, HOLD} state_t;
  state_t      state_q;
  logic        owner_q, ptr_q, lock_q, rd_q, data_q;
  logic [3:0]  sc_q;
  logic [7:0]  cnt_q;
  logic        idle, own_valid, elig0, elig1, gnt_any, gnt;
  assign key_br_w = 1'b1;
  always_comb begin
    idle      = state_q == IDLE;
    own_valid = owner_q ? req1_valid : req0_valid;
    // while locked, only the owner may be granted
    elig0     = req0_valid & ~(lock_q & owner_q);
    elig1     = req1_valid & ~(lock_q & ~owner_q);
    gnt_any   = idle & (elig0 | elig1);
    gnt       = (elig0 & elig1) ? ptr_q : elig1;
    // lock is still held this cycle, so a waiting requester wins only next cycle
    lock_drop = idle & lock_q & ~own_valid & (cnt_q == 8'(LOCK_TMO));
    req0_ready = gnt_any & ~gnt;
    req1_ready = gnt_any & gnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      lock_q     <= 1'b0;
      rd_q       <= 1'b0;
      data_q     <= 1'b0;
      sc_q       <= '0;
      cnt_q      <= '0;
      key_sser   <= 1'b1;
      key_ba     <= 6'b010000;
      key_clk    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= 1'b0;
      rsp1_data  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            owner_q  <= gnt;
            ptr_q    <= ~gnt;
            rd_q     <= gnt ? req1_rd : req0_rd;
            lock_q   <= gnt ? req1_lock : req0_lock;
            key_ba   <= {2'b01, gnt ? req1_nib : req0_nib};
            key_sser <= 1'b0;
            cnt_q    <= '0;
            sc_q     <= '0;
            state_q  <= SETUP;
          end else if (lock_drop) begin
            lock_q <= 1'b0;
            cnt_q  <= '0;
          end else if (lock_q && !own_valid) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SETUP: begin
          if (sc_q == 4'(SETUP_CYC - 1)) begin
            data_q  <= rd_q & key_sdrd;
            key_clk <= 1'b1;
            state_q <= CLK;
          end else begin
            sc_q <= sc_q + 4'd1;
          end
        end
        CLK: begin
          key_clk    <= 1'b0;
          rsp0_valid <= ~owner_q;
          rsp1_valid <= owner_q;
          rsp0_data  <= ~owner_q & data_q;
          rsp1_data  <= owner_q & data_q;
          state_q    <= HOLD;
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          rsp0_data  <= 1'b0;
          rsp1_data  <= 1'b0;
          key_sser   <= 1'b1;
          key_ba     <= 6'b010000;
          state_q    <= IDLE;
        end
      endcase
    end
  end
endmodule
